// File: rtl/ps2_device_tx_if.sv
// Request/handshake and PS/2 line bundle for the device-side PS/2 transmitter.
interface ps2_device_tx_if;
  logic [7:0] iData;
  logic       iValid;
  logic       iInhibit;
  logic       oReady;
  logic       oBusy;
  logic       oDone;
  logic       oAbort;
  logic       PS2_CLK;
  logic       PS2_DATA;

  modport master (
    output iData, iValid, iInhibit,
    input  oReady, oBusy, oDone, oAbort, PS2_CLK, PS2_DATA
  );

  modport slave (
    input  iData, iValid, iInhibit,
    output oReady, oBusy, oDone, oAbort, PS2_CLK, PS2_DATA
  );
endinterface

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: serialises one byte per request into an 11-bit
// frame (start, D0..D7, odd parity, stop) while generating PS2_CLK itself.
module ps2_device_tx #(
  parameter int unsigned HALF_PERIOD = 2500,
  parameter int unsigned GAP_CYCLES  = 5000
) (
  input logic          Clock,
  input logic          Reset,
  ps2_device_tx_if.slave bus
);

  localparam int unsigned TMAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX);
  localparam logic [TW-1:0] HP_LOAD  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [3:0]    LAST_IDX = 4'd10;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    idx, idx_n;
  logic [10:0]   frame, frame_n;
  logic          ps2_clk, ps2_clk_n;
  logic          ps2_data, ps2_data_n;
  logic          busy, busy_n;
  logic          done, done_n;
  logic          abort, abort_n;
  logic          ready;

  assign ready        = (state == IDLE) && !bus.iInhibit;
  assign bus.oReady   = ready;
  assign bus.oBusy    = busy;
  assign bus.oDone    = done;
  assign bus.oAbort   = abort;
  assign bus.PS2_CLK  = ps2_clk;
  assign bus.PS2_DATA = ps2_data;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      timer    <= '0;
      idx      <= '0;
      frame    <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      idx      <= idx_n;
      frame    <= frame_n;
      ps2_clk  <= ps2_clk_n;
      ps2_data <= ps2_data_n;
      busy     <= busy_n;
      done     <= done_n;
      abort    <= abort_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    idx_n      = idx;
    frame_n    = frame;
    ps2_clk_n  = ps2_clk;
    ps2_data_n = ps2_data;
    done_n     = 1'b0;
    abort_n    = 1'b0;

    case (state)
      IDLE: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        if (bus.iValid && ready) begin
          state_n    = HIGH;
          timer_n    = HP_LOAD;
          idx_n      = '0;
          frame_n    = {1'b1, ~^bus.iData, bus.iData, 1'b0};
          ps2_data_n = 1'b0;
        end
      end
      HIGH, LOW: begin
        // Inhibit aborts any bit except the stop bit, which is allowed to finish.
        if (bus.iInhibit && (idx != LAST_IDX)) begin
          state_n    = GAP;
          timer_n    = GAP_LOAD;
          ps2_clk_n  = 1'b1;
          ps2_data_n = 1'b1;
          abort_n    = 1'b1;
        end else if (timer != '0) begin
          timer_n = timer - T_ONE;
        end else if (state == HIGH) begin
          state_n   = LOW;
          timer_n   = HP_LOAD;
          ps2_clk_n = 1'b0;
        end else if (idx == LAST_IDX) begin
          state_n    = GAP;
          timer_n    = GAP_LOAD;
          ps2_clk_n  = 1'b1;
          ps2_data_n = 1'b1;
          done_n     = 1'b1;
        end else begin
          // Data moves only together with the rising clock edge.
          state_n    = HIGH;
          timer_n    = HP_LOAD;
          idx_n      = idx + 4'd1;
          frame_n    = {1'b0, frame[10:1]};
          ps2_clk_n  = 1'b1;
          ps2_data_n = frame[1];
        end
      end
      GAP: begin
        ps2_clk_n  = 1'b1;
        ps2_data_n = 1'b1;
        if (timer == '0) state_n = IDLE;
        else             timer_n = timer - T_ONE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: timing and frame contents are derived
// from the frame rules (phase = t / HALF_PERIOD) and compared cycle by cycle.
module tb_ps2_device_tx;
  localparam int HP = 4;
  localparam int GP = 8;

  logic Clock;
  logic Reset;
  int   n_cmp;
  int   n_bad;

  ps2_device_tx_if bus ();

  ps2_device_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GP)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lines();
    return {27'd0, bus.PS2_CLK, bus.PS2_DATA, bus.oDone, bus.oAbort, bus.oBusy};
  endfunction

  // Sends byte b; called at a negedge. hold keeps iValid high afterwards,
  // imm demands acceptance in the calling cycle, abort_k raises inhibit right
  // after the k-th falling edge, stop_inh raises inhibit during the stop bit.
  task automatic run_frame(input logic [7:0] b, input bit hold, input bit imm,
                           input int abort_k, input bit stop_inh);
    logic [10:0] mbits;
    logic [10:0] rxw;
    int   w, nf, c, phase;
    bit   prev_clk, aborted;
    logic [31:0] exp;

    mbits[0] = 1'b0;
    for (int i = 0; i < 8; i++) mbits[i+1] = (b >> i) & 8'd1;
    mbits[9]  = ($countones(b) % 2 == 0);
    mbits[10] = 1'b1;

    bus.iData  = b;
    bus.iValid = 1'b1;
    w = 0;
    while (!bus.oReady && w < 200) begin
      @(negedge Clock);
      w++;
    end
    chk("accept_wait_bounded", 32'(w < 200), 32'd1);
    if (imm) chk("accept_immediate", 32'(w), 32'd0);

    rxw = '0; nf = 0; prev_clk = 1'b1; aborted = 1'b0;
    for (int t = 0; t <= 22*HP; t++) begin
      @(negedge Clock);
      if (t == 0 && !hold) bus.iValid = 1'b0;
      phase = t / HP;
      if (phase < 22) exp = {27'd0, 1'(phase % 2 == 0), mbits[phase/2], 1'b0, 1'b0, 1'b1};
      else            exp = {27'd0, 5'b11101};
      chk("wire", lines(), exp);
      if (t == 0) chk("ready_busy", 32'(bus.oReady), 32'd0);
      if (prev_clk && !bus.PS2_CLK) begin
        chk("fall_time", 32'(t), 32'((2*nf + 1) * HP));
        if (nf < 11) rxw[nf] = bus.PS2_DATA;
        nf++;
      end
      prev_clk = bus.PS2_CLK;
      if (abort_k > 0 && t == (2*abort_k - 1) * HP) begin
        bus.iInhibit = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (stop_inh && t == 20*HP + 1) bus.iInhibit = 1'b1;
    end

    if (aborted) begin
      @(negedge Clock);
      chk("abort_pulse", lines(), {27'd0, 5'b11011});
      for (int g = 1; g < GP; g++) begin
        @(negedge Clock);
        chk("abort_gap", lines(), {27'd0, 5'b11001});
        chk("abort_gap_ready", 32'(bus.oReady), 32'd0);
      end
      @(negedge Clock);
      chk("abort_idle", lines(), {27'd0, 5'b11000});
      chk("inhibit_ready", 32'(bus.oReady), 32'd0);
      bus.iInhibit = 1'b0;
      #1;
      chk("release_ready", 32'(bus.oReady), 32'd1);
      return;
    end

    chk("fall_count", 32'(nf), 32'd11);
    chk("decoded", 32'(rxw), 32'(mbits));
    c = 0;
    do begin
      @(negedge Clock);
      c++;
      if (bus.oBusy) chk("gap_lines", lines(), {27'd0, 5'b11001});
    end while (bus.oBusy && c < 100);
    chk("gap_len", 32'(c), 32'(GP));
    chk("post_ready", 32'(bus.oReady), 32'(!bus.iInhibit));
    if (stop_inh) begin
      chk("stop_inh_ready", 32'(bus.oReady), 32'd0);
      bus.iInhibit = 1'b0;
      #1;
      chk("stop_release_ready", 32'(bus.oReady), 32'd1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b0;
    bus.iData = '0;
    bus.iValid = 1'b0;
    bus.iInhibit = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_lines", lines(), {27'd0, 5'b11000});
    Reset = 1'b1;
    @(negedge Clock);
    chk("idle_lines", lines(), {27'd0, 5'b11000});
    chk("idle_ready", 32'(bus.oReady), 32'd1);
    bus.iInhibit = 1'b1;
    bus.iValid = 1'b1;
    #1;
    chk("inhibit_idle_ready", 32'(bus.oReady), 32'd0);
    @(negedge Clock);
    chk("inhibit_no_accept", lines(), {27'd0, 5'b11000});
    bus.iValid = 1'b0;
    bus.iInhibit = 1'b0;
    @(negedge Clock);

    run_frame(8'h1C, 1'b0, 1'b1, 0, 1'b0);
    run_frame(8'h00, 1'b0, 1'b1, 0, 1'b0);
    run_frame(8'hFF, 1'b0, 1'b1, 0, 1'b0);
    for (int r = 0; r < 5; r++) run_frame(8'($urandom), 1'b0, 1'b1, 0, 1'b0);

    run_frame(8'hF0, 1'b1, 1'b1, 0, 1'b0);
    run_frame(8'h1C, 1'b0, 1'b1, 0, 1'b0);

    run_frame(8'hA5, 1'b0, 1'b1, 4, 1'b0);
    @(negedge Clock);
    run_frame(8'h5A, 1'b0, 1'b1, 0, 1'b1);

    bus.iData = 8'h3C;
    bus.iValid = 1'b1;
    for (int t = 0; t <= 3*HP + 1; t++) begin
      @(negedge Clock);
      bus.iValid = 1'b0;
    end
    chk("midframe_low", 32'(bus.PS2_CLK), 32'd0);
    Reset = 1'b0;
    #1;
    chk("async_reset_lines", lines(), {27'd0, 5'b11000});
    chk("async_reset_ready", 32'(bus.oReady), 32'd1);
    @(negedge Clock);
    Reset = 1'b1;
    run_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
